des_key_round_gen: RTL and testbench
====================================

Name: des_key_round_gen

Overview:
- Downstream consumer of the 56-bit key payload produced by the key-corruption stage.
- Latches the 56-bit post-PC-1 key (C = key[55:28], D = key[27:0]) on a start request.
- Produces the 16 per-round rotated CD values, pre-PC-2, one per accepted transfer, for the DES round datapath.
- Supports both encrypt (left-rotate) and decrypt (right-rotate) schedules, with a valid/ready handshake toward the round datapath.

Parameters:
- NUM_ROUNDS, 16, number of rounds generated per start; fixed at 16, any other value unsupported.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a schedule; honoured only when idle.
- decrypt  input  1  mode sampled with start; 0 = encrypt, 1 = decrypt.
- key_in  input  56  key payload, sampled with start.
- round_ready  input  1  downstream accepts round_key this cycle.
- round_key  output  56  rotated {C,D} for the current round.
- round_idx  output  4  round number 0..15 of round_key.
- round_valid  output  1  round_key/round_idx valid.
- busy  output  1  schedule in progress; start ignored.
- done  output  1  one-cycle pulse on acceptance of round 15.

Behaviour:
- Reset: synchronous active-high. On rst=1 at a posedge:
  - state = IDLE.
  - round_key = 0, round_idx = 0, round_valid = 0, busy = 0, done = 0.
  - Latched key and mode are cleared.
  - rst mid-schedule aborts immediately; no done pulse is produced.
- States: IDLE, RUN.
- IDLE --start=1--> RUN:
  - Latch key_in and decrypt.
  - Compute round 0: rotate C and D independently (28-bit rotates, never across halves) by shift[0].
  - At the next edge: round_valid=1, round_idx=0, busy=1.
  - Latency from start to first valid = 1 cycle.
- RUN, handshake:
  - Transfer occurs when round_valid && round_ready.
  - On transfer of round i<15: round_idx=i+1, and round_key = previous round_key rotated by shift[i+1], valid next cycle.
  - With round_ready held high, one round per cycle and 16 consecutive valid cycles.
  - While round_valid && !round_ready: round_key, round_idx and round_valid hold stable.
- Shift schedules (amounts for rounds 0..15):
  - Encrypt (rotate left): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt (rotate right): 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Both sum to 28 (encrypt) / 27 (decrypt).
  - Decrypt round 0 equals the latched key unchanged.
- Completion:
  - On transfer of round 15: done=1 for exactly that following cycle, round_valid=0, busy=0, state=IDLE.
  - round_key and round_idx keep their last values until the next start.
- Boundary conditions:
  - start while busy: ignored; key_in and decrypt are not resampled.
  - start in the same cycle as the done-causing transfer: ignored. The first start honoured is in the cycle after done.
  - start and rst together: rst wins.
  - round_ready while !round_valid: no effect.
  - Changes of decrypt or key_in during RUN: no effect.

Test Plan:
- Encrypt, D-half single bit: key_in=56'h00000000000001, start, round_ready=1 → round_key sequence 56'h00000000000002, 56'h00000000000004, 56'h00000000000010 for rounds 0..2. Round 15 = 56'h00000000000001. done pulses once; total 16 valid cycles.
- Half isolation: key_in=56'h80000000000000, encrypt → round 0 round_key = 56'h00000010000000 (C bit27 wraps to C bit0; D stays 0).
- Decrypt: key_in=56'h00000000000001, decrypt=1 → round 0 = 56'h00000000000001, round 1 = 56'h00000008000000. Round 15 equals the encrypt-mode round 0 value for the same key.
- Backpressure: round_ready=0 for 3 cycles while round_idx=4 → round_key, round_idx and round_valid are unchanged for those cycles; the schedule resumes at round 5 with the correct value; still exactly 16 transfers.
- Start while busy: second start with a different key at round 7 → ignored; the sequence completes with the original key; busy=1 throughout.
- Reset mid-operation: rst=1 at round 9 → next cycle all outputs are 0 and there is no done pulse. A fresh start then produces round 0 after 1 cycle.

Source files
------------

// File: rtl/des_key_round_gen.sv
// des_key_round_gen
// Per-round DES key schedule generator (pre-PC-2). A start in IDLE latches
// the 56-bit post-PC-1 key and the encrypt/decrypt mode, then the block
// presents 16 rotated {C,D} values, one per accepted valid/ready transfer.
// C = key[55:28] and D = key[27:0] rotate independently as 28-bit halves.
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst         - synchronous active-high reset
//   start       - begin a schedule (honoured only when idle)
//   decrypt     - mode sampled with start: 0 rotate left, 1 rotate right
//   key_in      - 56-bit key payload sampled with start
//   round_ready - downstream accepts round_key this cycle
//   round_key   - rotated {C,D} for round round_idx
//   round_idx   - round number 0..15
//   round_valid - round_key/round_idx valid
//   busy        - schedule in progress
//   done        - one-cycle pulse after the round-15 transfer
module des_key_round_gen #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [55:0] key_in,
    input  logic        round_ready,
    output logic [55:0] round_key,
    output logic [3:0]  round_idx,
    output logic        round_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    state_t      state, state_nxt;
    logic        mode, mode_nxt;
    logic [55:0] key_nxt;
    logic [3:0]  idx_nxt;
    logic        valid_nxt;
    logic        done_nxt;

    // Rotation amount for a given round. Decrypt round 0 is an identity so
    // the first decrypt key is the latched key itself.
    function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic dec);
        case (idx)
            4'd0:                shift_amt = dec ? 2'd0 : 2'd1;
            4'd1, 4'd8, 4'd15:   shift_amt = 2'd1;
            default:             shift_amt = 2'd2;
        endcase
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] h, input logic [1:0] amt,
                                          input logic dec);
        case (amt)
            2'd1:    rot28 = dec ? {h[0], h[27:1]}   : {h[26:0], h[27]};
            2'd2:    rot28 = dec ? {h[1:0], h[27:2]} : {h[25:0], h[27:26]};
            default: rot28 = h;
        endcase
    endfunction

    // Halves never exchange bits: each 28-bit half wraps on itself.
    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic [1:0] amt,
                                           input logic dec);
        rot_cd = {rot28(cd[55:28], amt, dec), rot28(cd[27:0], amt, dec)};
    endfunction

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        key_nxt   = round_key;
        idx_nxt   = round_idx;
        valid_nxt = round_valid;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    mode_nxt  = decrypt;
                    key_nxt   = rot_cd(key_in, shift_amt(4'd0, decrypt), decrypt);
                    idx_nxt   = 4'd0;
                    valid_nxt = 1'b1;
                end
            end
            RUN: begin
                if (round_valid && round_ready) begin
                    if (round_idx == LAST_IDX) begin
                        // round_key/round_idx keep their last values
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = round_idx + 4'd1;
                        key_nxt = rot_cd(round_key, shift_amt(round_idx + 4'd1, mode), mode);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode        <= 1'b0;
            round_key   <= '0;
            round_idx   <= '0;
            round_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode        <= mode_nxt;
            round_key   <= key_nxt;
            round_idx   <= idx_nxt;
            round_valid <= valid_nxt;
            done        <= done_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_des_key_round_gen.sv
// Directed testbench for des_key_round_gen: encrypt/decrypt schedules,
// half isolation, backpressure, start while busy, start on the done cycle,
// start with reset, and reset mid-schedule.
module tb_des_key_round_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [55:0] key_in;
    logic        round_ready;
    logic [55:0] round_key;
    logic [3:0]  round_idx;
    logic        round_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [55:0] cap [16];

    localparam int SCHED_E [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SCHED_D [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    des_key_round_gen #(.NUM_ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
        .round_ready(round_ready), .round_key(round_key), .round_idx(round_idx),
        .round_valid(round_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected key: move every bit by the cumulative shift, expressed as a
    // net left rotation of each 28-bit half.
    function automatic logic [55:0] model(input logic [55:0] k, input logic d, input int r);
        int total = 0;
        logic [55:0] o = '0;
        for (int i = 0; i <= r; i++) total += d ? SCHED_D[i] : SCHED_E[i];
        total = total % 28;
        if (d) total = (28 - total) % 28;
        for (int b = 0; b < 28; b++) begin
            o[28 + ((b + total) % 28)] = k[28 + b];
            o[(b + total) % 28]        = k[b];
        end
        return o;
    endfunction

    // Runs one schedule. stall_at: round held off for 3 cycles; restart_at:
    // round whose transfer coincides with a spurious start; rst_at: round at
    // which reset aborts the schedule. -1 disables an option.
    task automatic run(input logic [55:0] k, input logic d, input int stall_at,
                       input int restart_at, input int rst_at);
        start = 1'b1; key_in = k; decrypt = d; round_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("valid r%0d", i), 64'(round_valid), 64'd1);
            chk($sformatf("idx r%0d", i), 64'(round_idx), 64'(i));
            chk($sformatf("key r%0d", i), 64'(round_key), 64'(model(k, d, i)));
            chk($sformatf("busy r%0d", i), 64'(busy), 64'd1);
            chk($sformatf("done r%0d", i), 64'(done), 64'd0);
            cap[i] = round_key;
            if (i == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst key", 64'(round_key), 64'd0);
                chk("rst idx", 64'(round_idx), 64'd0);
                chk("rst valid", 64'(round_valid), 64'd0);
                chk("rst busy", 64'(busy), 64'd0);
                chk("rst done", 64'(done), 64'd0);
                tick();
                chk("rst done later", 64'(done), 64'd0);
                return;
            end
            if (i == stall_at) begin
                round_ready = 1'b0;
                repeat (3) begin
                    tick();
                    chk("stall valid", 64'(round_valid), 64'd1);
                    chk("stall idx", 64'(round_idx), 64'(i));
                    chk("stall key", 64'(round_key), 64'(cap[i]));
                    chk("stall done", 64'(done), 64'd0);
                end
                round_ready = 1'b1;
            end
            if (i == restart_at) begin
                start = 1'b1; key_in = ~k; decrypt = ~d;
            end
            tick();
            start = 1'b0; key_in = ~k; decrypt = ~d;
        end
        chk("done pulse", 64'(done), 64'd1);
        chk("end valid", 64'(round_valid), 64'd0);
        chk("end busy", 64'(busy), 64'd0);
        tick();
        chk("done clears", 64'(done), 64'd0);
        chk("idle valid", 64'(round_valid), 64'd0);
        chk("hold key", 64'(round_key), 64'(cap[15]));
        chk("hold idx", 64'(round_idx), 64'd15);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_in = '0; round_ready = 1'b0;
        tick();
        tick();
        chk("reset key", 64'(round_key), 64'd0);
        chk("reset idx", 64'(round_idx), 64'd0);
        chk("reset valid", 64'(round_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);

        // start together with reset: reset wins
        start = 1'b1; key_in = 56'h00000000000001;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst+start valid", 64'(round_valid), 64'd0);
        chk("rst+start busy", 64'(busy), 64'd0);
        tick();
        chk("rst+start still idle", 64'(busy), 64'd0);

        // encrypt, single D bit
        run(56'h00000000000001, 1'b0, -1, -1, -1);
        chk("enc r0", 64'(cap[0]), 64'h00000000000002);
        chk("enc r1", 64'(cap[1]), 64'h00000000000004);
        chk("enc r2", 64'(cap[2]), 64'h00000000000010);
        chk("enc r15", 64'(cap[15]), 64'h00000000000001);

        // half isolation: C bit 27 wraps to C bit 0
        run(56'h80000000000000, 1'b0, -1, -1, -1);
        chk("iso r0", 64'(cap[0]), 64'h00000010000000);

        // decrypt
        run(56'h00000000000001, 1'b1, -1, -1, -1);
        chk("dec r0", 64'(cap[0]), 64'h00000000000001);
        chk("dec r1", 64'(cap[1]), 64'h00000008000000);
        chk("dec r15", 64'(cap[15]), 64'h00000000000002);

        // backpressure at round 4
        run(56'h123456789ABCDE, 1'b0, 4, -1, -1);

        // start while busy at round 7
        run(56'h0F0F0F0F0F0F0F, 1'b1, -1, 7, -1);

        // start on the done-causing transfer is ignored
        run(56'hA5A5A5A5A5A5A5, 1'b0, -1, 15, -1);

        // reset mid-schedule, then a fresh start
        run(56'hDEADBEEFCAFE12, 1'b0, -1, -1, 9);
        run(56'h00000000000001, 1'b0, -1, -1, -1);
        chk("fresh r0", 64'(cap[0]), 64'h00000000000002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
